// File: rtl/cmp_harness_pkg.sv
// Shared types and helpers for the compressor serial test harness.
package cmp_harness_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        EVAL  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    // One phase counter serves every state, so it must hold the longest phase length.
    function automatic int cnt_width(input int src_width, input int dst_bits, input int eval_lat);
        int m;
        m = src_width;
        if (dst_bits > m)     m = dst_bits;
        if (eval_lat + 1 > m) m = eval_lat + 1;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/cmp_sipo_chan.sv
// One operand channel: serial-in shift register, newest bit enters at the LSB.
module cmp_sipo_chan #(
    parameter int SRC_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 shift_en_i,
    input  logic                 bit_i,
    output logic [SRC_WIDTH-1:0] data_o
);

    logic [SRC_WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (shift_en_i) begin
            data_q <= {data_q[SRC_WIDTH-2:0], bit_i};
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/cmp_shift_harness.sv
// Serial fill / evaluate / serial drain harness around an external compressor tree.
//
//   state | meaning
//   IDLE  | waiting for start, operands keep previous contents
//   FILL  | SRC_WIDTH cycles, every channel shifts in one bit
//   EVAL  | EVAL_LAT+1 cycles, src_bus stable; dst_bus captured on the last edge
//   DRAIN | DST_BITS cycles, capture register shifted out LSB first
//   DONE  | single cycle, done pulse
module cmp_shift_harness
    import cmp_harness_pkg::*;
#(
    parameter int NUM_SRC   = 20,
    parameter int SRC_WIDTH = 20,
    parameter int DST_BITS  = 25,
    parameter int EVAL_LAT  = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [NUM_SRC-1:0]           src_in,
    output logic [NUM_SRC*SRC_WIDTH-1:0] src_bus,
    input  logic [DST_BITS-1:0]          dst_bus,
    output logic                         dst_out,
    output logic                         dst_out_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int CW = cnt_width(SRC_WIDTH, DST_BITS, EVAL_LAT);
    localparam logic [CW-1:0] FILL_LAST  = CW'(SRC_WIDTH - 1);
    localparam logic [CW-1:0] EVAL_LAST  = CW'(EVAL_LAT);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DST_BITS - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DST_BITS-1:0] cap_q, cap_d;
    logic                shift_en;
    logic                dst_out_q, dst_out_valid_q, busy_q, done_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_chan
        cmp_sipo_chan #(.SRC_WIDTH(SRC_WIDTH)) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .shift_en_i (shift_en),
            .bit_i      (src_in[i]),
            .data_o     (src_bus[i*SRC_WIDTH +: SRC_WIDTH])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        cap_d    = cap_q;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) state_d = FILL;
            end
            FILL: begin
                shift_en = 1'b1;
                if (cnt_q == FILL_LAST) begin
                    state_d = EVAL;
                    cnt_d   = '0;
                end
            end
            EVAL: begin
                if (cnt_q == EVAL_LAST) begin
                    cap_d   = dst_bus;
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cap_d = cap_q >> 1;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from next state so they are flops aligned with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            cap_q           <= '0;
            dst_out_q       <= 1'b0;
            dst_out_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cap_q           <= cap_d;
            dst_out_q       <= (state_d == DRAIN) & cap_d[0];
            dst_out_valid_q <= (state_d == DRAIN);
            busy_q          <= (state_d != IDLE);
            done_q          <= (state_d == DONE);
        end
    end

    assign dst_out       = dst_out_q;
    assign dst_out_valid = dst_out_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_cmp_shift_harness.sv
// Directed bench: default harness, two pipelined-compressor variants and a minimal corner build.
module tb_cmp_shift_harness;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Default build, compressor is either a loopback or the sum of all operands
    logic         start0 = 1'b0;
    logic [19:0]  src0 = '0;
    logic [399:0] bus0;
    logic [24:0]  dst0, sum0;
    logic         dout0, dval0, busy0, done0;
    logic         use_sum = 1'b0;
    logic [19:0]  ops0 [20];

    always_comb begin
        sum0 = '0;
        for (int i = 0; i < 20; i++) sum0 = sum0 + 25'(bus0[i*20 +: 20]);
    end
    assign dst0 = use_sum ? sum0 : bus0[24:0];

    cmp_shift_harness dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .src_in(src0), .src_bus(bus0),
        .dst_bus(dst0), .dst_out(dout0), .dst_out_valid(dval0), .busy(busy0), .done(done0));

    // Two builds fed by a 3-stage pipelined adder: EVAL_LAT 3 (enough) and 2 (too short)
    logic        start_p = 1'b0;
    logic [1:0]  src_p = '0;
    logic [15:0] bus1, bus2;
    logic [8:0]  p1a, p1b, p1c, p2a, p2b, p2c;
    logic        dout1, dval1, busy1, done1, dout2, dval2, busy2, done2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1a <= '0; p1b <= '0; p1c <= '0;
            p2a <= '0; p2b <= '0; p2c <= '0;
        end else begin
            p1a <= 9'(bus1[7:0]) + 9'(bus1[15:8]); p1b <= p1a; p1c <= p1b;
            p2a <= 9'(bus2[7:0]) + 9'(bus2[15:8]); p2b <= p2a; p2c <= p2b;
        end
    end

    cmp_shift_harness #(.NUM_SRC(2), .SRC_WIDTH(8), .DST_BITS(9), .EVAL_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_p), .src_in(src_p), .src_bus(bus1),
        .dst_bus(p1c), .dst_out(dout1), .dst_out_valid(dval1), .busy(busy1), .done(done1));

    cmp_shift_harness #(.NUM_SRC(2), .SRC_WIDTH(8), .DST_BITS(9), .EVAL_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_p), .src_in(src_p), .src_bus(bus2),
        .dst_bus(p2c), .dst_out(dout2), .dst_out_valid(dval2), .busy(busy2), .done(done2));

    // Minimal corner build
    logic       start3 = 1'b0;
    logic [0:0] src3 = '0;
    logic [1:0] bus3;
    logic [0:0] dst3;
    logic       dout3, dval3, busy3, done3;
    assign dst3 = bus3[1] & bus3[0];

    cmp_shift_harness #(.NUM_SRC(1), .SRC_WIDTH(2), .DST_BITS(1), .EVAL_LAT(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .src_in(src3), .src_bus(bus3),
        .dst_bus(dst3), .dst_out(dout3), .dst_out_valid(dval3), .busy(busy3), .done(done3));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One default-build transaction; c counts cycles after the edge that sampled start.
    task automatic run0(input int pa, input int pb, output int busy_n, output int val_n,
                        output int done_n, output int done_at, output logic [24:0] ser);
        busy_n = 0; val_n = 0; done_n = 0; done_at = 0; ser = '0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            start0 = (c == pa) || (c == pb);
            for (int i = 0; i < 20; i++) begin
                src0[i] = 1'b0;
                if (c <= 20) src0[i] = ops0[i][20-c];
            end
            if (busy0) busy_n++;
            if (dval0) begin
                if (val_n < 25) ser[val_n] = dout0;
                val_n++;
            end
            if (done0) begin
                done_n++;
                done_at = c;
            end
            step();
        end
        start0 = 1'b0;
        src0   = '0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        step(); step();
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy0); end
        n_vec++; if (done0 !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done0); end
        n_vec++; if (dval0 !== 1'b0 || dout0 !== 1'b0) begin n_err++; $display("FAIL reset_dout got %b%b want 00", dval0, dout0); end
        n_vec++; if (bus0 !== '0) begin n_err++; $display("FAIL reset_src_bus got %h want 0", bus0); end
        n_vec++; if (busy1 !== 1'b0 || busy3 !== 1'b0 || bus3 !== 2'b00) begin n_err++; $display("FAIL reset_others got %b %b %b", busy1, busy3, bus3); end
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_drain();
        int dn, bn, vn, dcnt, dat;
        logic [24:0] ser;
        for (int i = 0; i < 20; i++) ops0[i] = 20'(32'h9E3B5 * (i + 1));
        use_sum = 1'b1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            for (int i = 0; i < 20; i++) begin
                src0[i] = 1'b0;
                if (c <= 20) src0[i] = ops0[i][20-c];
            end
            if (c < 31) step();
        end
        n_vec++; if (dval0 !== 1'b1 || busy0 !== 1'b1) begin n_err++; $display("FAIL mid_drain_state got valid=%b busy=%b want 1 1", dval0, busy0); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({busy0, done0, dval0, dout0} !== 4'b0000) begin n_err++; $display("FAIL reset_abort_outputs got %b want 0000", {busy0, done0, dval0, dout0}); end
        n_vec++; if (bus0 !== '0) begin n_err++; $display("FAIL reset_abort_src_bus got %h want 0", bus0); end
        @(negedge clk) rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 60; c++) begin
            if (done0 || busy0) dn++;
            step();
        end
        n_vec++; if (dn !== 0) begin n_err++; $display("FAIL reset_no_done got %0d active cycles want 0", dn); end
        run0(0, 0, bn, vn, dcnt, dat, ser);
        n_vec++; if (bn !== 47) begin n_err++; $display("FAIL post_reset_busy got %0d want 47", bn); end
        n_vec++; if (dat !== 47 || dcnt !== 1) begin n_err++; $display("FAIL post_reset_done got at=%0d n=%0d want 47 1", dat, dcnt); end
    endtask

    task automatic test_loopback();
        int bn, vn, dcnt, dat;
        logic [24:0] ser;
        for (int i = 0; i < 20; i++) ops0[i] = '0;
        ops0[0] = 20'hABCDE;
        ops0[1] = 20'h12345;
        use_sum = 1'b0;
        run0(0, 0, bn, vn, dcnt, dat, ser);
        n_vec++; if (bus0[39:0] !== 40'h12345ABCDE) begin n_err++; $display("FAIL loop_src_bus got %h want 12345abcde", bus0[39:0]); end
        n_vec++; if (ser !== 25'h05ABCDE) begin n_err++; $display("FAIL loop_serial got %h want 05abcde", ser); end
        n_vec++; if (vn !== 25) begin n_err++; $display("FAIL loop_valid_len got %0d want 25", vn); end
        n_vec++; if (bn !== 47) begin n_err++; $display("FAIL loop_busy_len got %0d want 47", bn); end
        n_vec++; if (dat !== 47 || dcnt !== 1) begin n_err++; $display("FAIL loop_done got at=%0d n=%0d want 47 1", dat, dcnt); end
    endtask

    task automatic test_pipelined_eval();
        logic [7:0] a, b;
        logic [8:0] s1, s2;
        int v1, v2, d1, d2;
        a = 8'hC3; b = 8'h5A;
        s1 = '0; s2 = '0; v1 = 0; v2 = 0; d1 = 0; d2 = 0;
        start_p = 1'b1;
        step();
        start_p = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            src_p = 2'b00;
            if (c <= 8) src_p = {b[8-c], a[8-c]};
            if (dval1) begin if (v1 < 9) s1[v1] = dout1; v1++; end
            if (dval2) begin if (v2 < 9) s2[v2] = dout2; v2++; end
            if (done1) d1 = c;
            if (done2) d2 = c;
            step();
        end
        src_p = 2'b00;
        n_vec++; if (s1 !== 9'h11D) begin n_err++; $display("FAIL pipe_lat3_result got %h want 11d", s1); end
        n_vec++; if (d1 !== 22) begin n_err++; $display("FAIL pipe_lat3_done got %0d want 22", d1); end
        n_vec++; if (s2 !== 9'h08E) begin n_err++; $display("FAIL pipe_lat2_stale got %h want 08e", s2); end
        n_vec++; if (d2 !== 21) begin n_err++; $display("FAIL pipe_lat2_done got %0d want 21", d2); end
    endtask

    task automatic test_start_ignored();
        int bn, vn, dcnt, dat;
        logic [24:0] ser, es;
        es = '0;
        for (int i = 0; i < 20; i++) begin
            ops0[i] = 20'(32'h5A5A5 + i * 32'h1F0F3);
            es = es + 25'(ops0[i]);
        end
        use_sum = 1'b1;
        run0(5, 30, bn, vn, dcnt, dat, ser);
        n_vec++; if (dcnt !== 1) begin n_err++; $display("FAIL ignore_done_count got %0d want 1", dcnt); end
        n_vec++; if (bn !== 47 || dat !== 47) begin n_err++; $display("FAIL ignore_length got busy=%0d done_at=%0d want 47 47", bn, dat); end
        n_vec++; if (ser !== es) begin n_err++; $display("FAIL ignore_result got %h want %h", ser, es); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] obb [3][20];
        logic [24:0] es [3];
        logic [24:0] rs [3];
        int dat [3];
        int dn, bi, t, f;
        for (int k = 0; k < 3; k++) begin
            es[k] = '0; rs[k] = '0; dat[k] = 0;
            for (int i = 0; i < 20; i++) begin
                obb[k][i] = 20'($urandom);
                es[k] = es[k] + 25'(obb[k][i]);
            end
        end
        dn = 0; bi = 0;
        use_sum = 1'b1;
        start0 = 1'b1;
        step();
        for (int c = 1; c <= 150; c++) begin
            if (c == 97) start0 = 1'b0;
            t = (c - 1) / 48;
            f = (c - 1) % 48 + 1;
            for (int i = 0; i < 20; i++) begin
                src0[i] = 1'b0;
                if (f <= 20 && t < 3) src0[i] = obb[t][i][20-f];
            end
            if (dval0) begin
                if (dn < 3 && bi < 25) rs[dn][bi] = dout0;
                bi++;
            end
            if (done0) begin
                if (dn < 3) dat[dn] = c;
                dn++;
                bi = 0;
            end
            step();
        end
        start0 = 1'b0;
        src0   = '0;
        n_vec++; if (dn !== 3) begin n_err++; $display("FAIL b2b_done_count got %0d want 3", dn); end
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (dat[k] !== 47 + 48 * k) begin n_err++; $display("FAIL b2b_done_at[%0d] got %0d want %0d", k, dat[k], 47 + 48 * k); end
            n_vec++; if (rs[k] !== es[k]) begin n_err++; $display("FAIL b2b_result[%0d] got %h want %h", k, rs[k], es[k]); end
        end
    endtask

    task automatic test_corner();
        logic [1:0] pat [2];
        logic       exp_bit [2];
        int bn, vn, dat;
        logic sb;
        pat[0] = 2'b11; exp_bit[0] = 1'b1;
        pat[1] = 2'b10; exp_bit[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bn = 0; vn = 0; dat = 0; sb = 1'bx;
            start3 = 1'b1;
            step();
            start3 = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                src3 = 1'b0;
                if (c <= 2) src3[0] = pat[k][2-c];
                if (busy3) bn++;
                if (dval3) begin sb = dout3; vn++; end
                if (done3) dat = c;
                step();
            end
            n_vec++; if (bn !== 5 || dat !== 5) begin n_err++; $display("FAIL corner_len[%0d] got busy=%0d done_at=%0d want 5 5", k, bn, dat); end
            n_vec++; if (vn !== 1 || sb !== exp_bit[k]) begin n_err++; $display("FAIL corner_out[%0d] got n=%0d bit=%b want 1 %b", k, vn, sb, exp_bit[k]); end
            n_vec++; if (bus3 !== pat[k]) begin n_err++; $display("FAIL corner_src_bus[%0d] got %b want %b", k, bus3, pat[k]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 20; i++) ops0[i] = '0;
        test_reset();
        test_reset_mid_drain();
        test_loopback();
        test_pipelined_eval();
        test_start_ignored();
        test_back_to_back();
        test_corner();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
